// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac
//  Purpose  : Parametrised fixed-point neuron. Accumulates exactly FAN_IN
//             signed X*W products on top of a per-neuron bias, rescales by
//             FRAC_BITS, saturates to DATA_W bits and optionally applies ReLU.
//  Ports    : Clk, Reset      - clock, synchronous active-high reset
//             Start, Bias     - begin a dot product, bias sampled with Start
//             In_valid, X, W  - one activation/weight pair per valid cycle
//             Busy            - high while accumulating or finishing
//             Out_valid       - one-cycle pulse when Z/Overflow update
//             Z, Overflow     - result and saturation flag, held
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_mac #(
   parameter int FAN_IN    = 784,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 13,
   parameter int ACC_W     = 42,
   parameter int RELU      = 1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic signed [DATA_W-1:0] Bias,
   input  logic                     In_valid,
   input  logic signed [DATA_W-1:0] X,
   input  logic signed [DATA_W-1:0] W,
   output logic                     Busy,
   output logic                     Out_valid,
   output logic signed [DATA_W-1:0] Z,
   output logic                     Overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Representable output range, expressed at accumulator width so the
   // saturation compare is a plain signed comparison.
   localparam logic signed [ACC_W-1:0] c_Z_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_Z_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [15:0] c_FAN_IN = 16'(FAN_IN);

   state_t                    r_state;
   state_t                    w_state_next;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [ACC_W-1:0]   w_acc_next;
   logic [15:0]               r_count;
   logic [15:0]               w_count_next;
   logic [15:0]               w_count_inc;
   logic signed [DATA_W-1:0]  r_z;
   logic signed [DATA_W-1:0]  w_z_next;
   logic                      r_ovf;
   logic                      w_ovf_next;
   logic                      r_out_valid;
   logic                      w_out_valid_next;
   logic                      r_busy;

   logic signed [ACC_W-1:0]      w_bias_ext;
   logic signed [2*DATA_W-1:0]   w_prod;
   logic signed [ACC_W-1:0]      w_prod_ext;
   logic signed [ACC_W-1:0]      w_shift;
   logic signed [DATA_W-1:0]     w_sat;
   logic                         w_sat_ovf;
   logic signed [DATA_W-1:0]     w_z_res;

   // Bias shares the Q format of Z, so it is aligned to the product format
   // (2*FRAC_BITS fractional bits) by shifting left by FRAC_BITS.
   assign w_bias_ext = {{(ACC_W-DATA_W){Bias[DATA_W-1]}}, Bias} <<< FRAC_BITS;
   assign w_prod     = X * W;
   assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
   assign w_count_inc = r_count + 16'd1;

   // Result path: arithmetic shift floors toward -inf.
   assign w_shift = r_acc >>> FRAC_BITS;

   always_comb begin
      w_sat     = w_shift[DATA_W-1:0];
      w_sat_ovf = 1'b0;
      if (w_shift > c_Z_MAX) begin
         w_sat     = c_Z_MAX[DATA_W-1:0];
         w_sat_ovf = 1'b1;
      end else if (w_shift < c_Z_MIN) begin
         w_sat     = c_Z_MIN[DATA_W-1:0];
         w_sat_ovf = 1'b1;
      end
   end

   // ReLU clamps the output only; Overflow still reports saturation.
   assign w_z_res = ((RELU != 0) && w_sat[DATA_W-1]) ? '0 : w_sat;

   always_comb begin
      w_state_next     = r_state;
      w_acc_next       = r_acc;
      w_count_next     = r_count;
      w_z_next         = r_z;
      w_ovf_next       = r_ovf;
      w_out_valid_next = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_acc_next   = w_bias_ext;
               w_count_next = '0;
               w_state_next = S_ACCUM;
            end
         end
         S_ACCUM: begin
            // Start takes priority: abort and restart with the new bias,
            // discarding any sample presented in the same cycle.
            if (Start) begin
               w_acc_next   = w_bias_ext;
               w_count_next = '0;
            end else if (In_valid) begin
               w_acc_next   = r_acc + w_prod_ext;
               w_count_next = w_count_inc;
               if (w_count_inc == c_FAN_IN) begin
                  w_state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_z_next         = w_z_res;
            w_ovf_next       = w_sat_ovf;
            w_out_valid_next = 1'b1;
            w_state_next     = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_z         <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_acc       <= w_acc_next;
         r_count     <= w_count_next;
         r_z         <= w_z_next;
         r_ovf       <= w_ovf_next;
         r_out_valid <= w_out_valid_next;
         r_busy      <= (w_state_next != S_IDLE);
      end
   end

   assign Busy      = r_busy;
   assign Out_valid = r_out_valid;
   assign Z         = r_z;
   assign Overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_mac
//  Purpose  : Self-checking bench for neuron_mac. Two FAN_IN=4 instances
//             (RELU=1 and RELU=0) share one stimulus stream; a FAN_IN=1
//             instance exercises single-sample and back-to-back operation.
//             Expected results come from an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               start_ab, in_valid_ab;
   logic               start_c, in_valid_c;
   logic signed [15:0] bias, x, w;

   logic               busy_a, ov_a, ovf_a;
   logic signed [15:0] z_a;
   logic               busy_b, ov_b, ovf_b;
   logic signed [15:0] z_b;
   logic               busy_c, ov_c, ovf_c;
   logic signed [15:0] z_c;

   int checks   = 0;
   int failures = 0;

   logic signed [15:0] vx[4];
   logic signed [15:0] vw[4];

   neuron_mac #(.FAN_IN(4), .DATA_W(16), .FRAC_BITS(13), .ACC_W(42), .RELU(1)) u_a (
      .Clk(clk), .Reset(rst), .Start(start_ab), .Bias(bias), .In_valid(in_valid_ab),
      .X(x), .W(w), .Busy(busy_a), .Out_valid(ov_a), .Z(z_a), .Overflow(ovf_a));

   neuron_mac #(.FAN_IN(4), .DATA_W(16), .FRAC_BITS(13), .ACC_W(42), .RELU(0)) u_b (
      .Clk(clk), .Reset(rst), .Start(start_ab), .Bias(bias), .In_valid(in_valid_ab),
      .X(x), .W(w), .Busy(busy_b), .Out_valid(ov_b), .Z(z_b), .Overflow(ovf_b));

   neuron_mac #(.FAN_IN(1), .DATA_W(16), .FRAC_BITS(13), .ACC_W(42), .RELU(1)) u_c (
      .Clk(clk), .Reset(rst), .Start(start_c), .Bias(bias), .In_valid(in_valid_c),
      .X(x), .W(w), .Busy(busy_c), .Out_valid(ov_c), .Z(z_c), .Overflow(ovf_c));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Real-valued view of the neuron: bias + sum(x*w) in Q.13 units,
   // floored, clipped to 16 bits, then ReLU.
   function automatic void model(input logic signed [15:0] b, input int n, input bit relu,
                                 output logic [15:0] z, output logic ov);
      longint acc;
      longint r;
      acc = longint'(b) * 64'sd8192;
      for (int i = 0; i < n; i++) acc += longint'(vx[i]) * longint'(vw[i]);
      r = acc >>> 13;
      ov = 1'b0;
      if (r > 32767) begin
         z = 16'h7FFF; ov = 1'b1;
      end else if (r < -32768) begin
         z = 16'h8000; ov = 1'b1;
      end else begin
         z = r[15:0];
      end
      if (relu && z[15]) z = 16'h0000;
   endfunction

   // One FAN_IN=4 operation on instances A and B. Optional random bubbles,
   // optional abort (Start again with abort_bias after abort_at samples).
   task automatic do_op(input string tag, input logic signed [15:0] b, input bit bubbles,
                        input int abort_at, input logic signed [15:0] abort_bias);
      int idx = 0;
      int guard = 0;
      bit aborted = 1'b0;
      logic signed [15:0] eff_bias = b;
      logic [15:0] ez_a, ez_b;
      logic eo_a, eo_b;
      start_ab = 1'b1; bias = b;
      in_valid_ab = 1'($urandom); x = 16'($urandom); w = 16'($urandom);
      step();
      start_ab = 1'b0;
      chk({tag, "_busy_start"}, {30'd0, busy_a, busy_b}, 32'h3);
      while (idx < 4 && guard < 100) begin
         guard++;
         if (!aborted && abort_at >= 0 && idx == abort_at) begin
            start_ab = 1'b1; bias = abort_bias; eff_bias = abort_bias;
            in_valid_ab = 1'b1; x = 16'($urandom); w = 16'($urandom);
            aborted = 1'b1; idx = 0;
         end else if (bubbles && ($urandom_range(0, 2) == 0)) begin
            in_valid_ab = 1'b0; x = 16'($urandom); w = 16'($urandom);
         end else begin
            in_valid_ab = 1'b1; x = vx[idx]; w = vw[idx]; idx++;
         end
         step();
         start_ab = 1'b0;
         chk({tag, "_accum_busy_nov"}, {29'd0, busy_a, ov_a, ov_b}, 32'h4);
      end
      chk({tag, "_guard"}, 32'(idx), 32'd4);
      // DONE cycle: Start and In_valid must both be ignored.
      start_ab = 1'b1; in_valid_ab = 1'b1; x = 16'h7FFF; w = 16'h7FFF; bias = 16'h1234;
      step();
      start_ab = 1'b0; in_valid_ab = 1'b0;
      model(eff_bias, 4, 1'b1, ez_a, eo_a);
      model(eff_bias, 4, 1'b0, ez_b, eo_b);
      chk({tag, "_ov_nbusy"}, {28'd0, ov_a, ov_b, busy_a, busy_b}, 32'hC);
      chk({tag, "_za"}, {15'd0, ovf_a, z_a}, {15'd0, eo_a, ez_a});
      chk({tag, "_zb"}, {15'd0, ovf_b, z_b}, {15'd0, eo_b, ez_b});
      step();
      chk({tag, "_pulse_end"}, {30'd0, ov_a, ov_b}, 32'h0);
      chk({tag, "_hold"}, {z_a, z_b}, {ez_a, ez_b});
   endtask

   task automatic fill(input logic [15:0] xv, input logic [15:0] wv);
      for (int i = 0; i < 4; i++) begin vx[i] = xv; vw[i] = wv; end
   endtask

   initial begin
      logic [15:0] ez;
      logic eo;
      rst = 1'b1; start_ab = 1'b0; in_valid_ab = 1'b0; start_c = 1'b0; in_valid_c = 1'b0;
      bias = '0; x = '0; w = '0;
      step(); step();
      rst = 1'b0;
      chk("reset_outputs", {busy_a, ov_a, ovf_a, busy_b, ov_b, ovf_b, busy_c, ov_c, ovf_c, 7'd0},
          16'h0);
      chk("reset_z", {z_a, z_b}, 32'h0);
      chk("reset_zc", {16'd0, z_c}, 32'h0);

      // Idle: In_valid without Start does nothing.
      in_valid_ab = 1'b1; x = 16'h2000; w = 16'h2000;
      step(); step();
      in_valid_ab = 1'b0;
      chk("idle_ignore", {29'd0, busy_a, ov_a, ov_b}, 32'h0);

      // Directed vectors from the plan.
      fill(16'h2000, 16'h1000); do_op("half_x4",    16'sh0000, 1'b0, -1, 16'sh0);
      fill(16'h2000, 16'h1000); do_op("bias_bub",   16'shF000, 1'b1, -1, 16'sh0);
      fill(16'h7FFF, 16'h7FFF); do_op("max_sat",    16'sh0000, 1'b0, -1, 16'sh0);
      fill(16'h8000, 16'h7FFF); do_op("min_sat",    16'sh0000, 1'b0, -1, 16'sh0);
      fill(16'hE000, 16'h2000); do_op("neg_relu",   16'sh0000, 1'b0, -1, 16'sh0);
      fill(16'hF000, 16'h2000); do_op("neg_two",    16'sh0000, 1'b0, -1, 16'sh0);
      fill(16'h2000, 16'h2000); do_op("abort",      16'sh0400, 1'b0,  2, 16'sh0000);

      // Random vectors, biased toward both small and full-scale values.
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 4; i++) begin
            vx[i] = (k % 2) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF) - 16'h2000);
            vw[i] = (k % 2) ? 16'($urandom) : 16'($urandom_range(0, 16'h3FFF) - 16'h2000);
         end
         do_op("rand", 16'($urandom), 1'b1, (k % 4 == 3) ? 1 : -1, 16'($urandom));
      end

      // Reset after 3 samples: everything returns to 0 with no result.
      fill(16'h2000, 16'h2000); do_op("pre_reset", 16'sh1000, 1'b0, -1, 16'sh0);
      start_ab = 1'b1; bias = 16'h1000; step(); start_ab = 1'b0;
      for (int i = 0; i < 3; i++) begin in_valid_ab = 1'b1; step(); end
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_reset", {z_a, 12'd0, busy_a, ov_a, ovf_a, busy_b}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         in_valid_ab = 1'b1; step();
         chk("post_reset_quiet", {30'd0, ov_a, busy_a}, 32'h0);
      end
      in_valid_ab = 1'b0;

      // FAN_IN=1: first op directed, then back-to-back Start in Out_valid cycle.
      vx[0] = 16'h2000; vw[0] = 16'h2000;
      start_c = 1'b1; bias = 16'h2000; step(); start_c = 1'b0;
      for (int k = 0; k < 8; k++) begin
         logic signed [15:0] cur_bias;
         cur_bias = bias;
         in_valid_c = 1'b1; x = vx[0]; w = vw[0];
         step();
         in_valid_c = 1'b0;
         chk("c_done_busy", {30'd0, busy_c, ov_c}, 32'h2);
         step();
         model(cur_bias, 1, 1'b1, ez, eo);
         chk("c_result", {14'd0, ov_c, ovf_c, z_c}, {14'd0, 1'b1, eo, ez});
         chk("c_busy_low", {31'd0, busy_c}, 32'h0);
         if (k < 7) begin
            vx[0] = 16'($urandom); vw[0] = 16'($urandom);
            start_c = 1'b1; bias = 16'($urandom); step(); start_c = 1'b0;
            chk("c_b2b_busy", {30'd0, busy_c, ov_c}, 32'h2);
         end
      end
      step();
      chk("c_quiet", {31'd0, ov_c}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
